// File: rtl/code_mem_ctrl.sv
// Code memory controller: arbitrates the single code memory port between the
// instruction-fetch requester and the boot/debug loader, sequences reads and
// writes, decodes user/system bank, protects the system bank against loader
// writes, and reports faulted accesses.
//
// Optional feature: define CODE_MEM_CTRL_RR_EN for round-robin arbitration
// between loader and fetch. When it is undefined the loader has fixed priority.
//
// Ports:
//   iCLK, iRST                 clock, asynchronous active-high reset
//   iFetchReq/iFetchAddr       fetch request (held until oFetchValid)
//   oFetchData/oFetchValid     fetch read data and one-cycle completion pulse
//   iLoadReq/iLoadAddr/iLoadData  loader write request (held until oLoadAck)
//   iSysWrEn                   permits loader writes to the system bank
//   oLoadAck                   one-cycle loader completion pulse
//   oMemAddr/oMemWData         word index and write data to both banks
//   oMemWrUser/oMemWrSys       one-cycle bank write enables
//   iMemDataUser/iMemDataSys   bank read data
//   oFault/oFaultAddr          fault pulse and address of the latest fault
//   oBusy                      controller not idle
module code_mem_ctrl #(
    parameter logic [63:0] USER_LIMIT = 64'h0000_1000,
    parameter logic [63:0] SYS_LIMIT  = 64'h0000_1800,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFetchReq,
    input  logic [63:0] iFetchAddr,
    output logic [63:0] oFetchData,
    output logic        oFetchValid,
    input  logic        iLoadReq,
    input  logic [63:0] iLoadAddr,
    input  logic [63:0] iLoadData,
    input  logic        iSysWrEn,
    output logic        oLoadAck,
    output logic [11:0] oMemAddr,
    output logic [63:0] oMemWData,
    output logic        oMemWrUser,
    output logic        oMemWrSys,
    input  logic [63:0] iMemDataUser,
    input  logic [63:0] iMemDataSys,
    output logic        oFault,
    output logic [63:0] oFaultAddr,
    output logic        oBusy
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR,
        RESP_FAULT
    } state_t;

    state_t             state;
    state_t             nextState;
    logic [CNT_W-1:0]   waitCnt;
    logic               sysSelQ;
    logic [63:0]        fetchDataQ;
    logic [63:0]        bankData;

    logic               grant;
    logic               loadWins;
    logic               reqIsWrite;
    logic               reqSys;
    logic               reqFault;
    logic [63:0]        reqAddr;

    // Arbitration: decide whether the loader wins when requests are present
`ifdef CODE_MEM_CTRL_RR_EN
    logic prioLoad;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            prioLoad <= 1'b1;
        end else if (grant) begin
            prioLoad <= !loadWins;
        end
    end

    always_comb begin
        loadWins = iLoadReq && (prioLoad || !iFetchReq);
    end
`else
    always_comb begin
        loadWins = iLoadReq;
    end
`endif

    // Request mux and fault check on the winning request
    always_comb begin
        reqAddr    = iFetchAddr;
        reqIsWrite = 1'b0;
        if (loadWins) begin
            reqAddr    = iLoadAddr;
            reqIsWrite = 1'b1;
        end
        // Addresses at or past SYS_LIMIT fault regardless of this flag
        reqSys   = (reqAddr >= USER_LIMIT);
        reqFault = (reqAddr[1:0] != 2'b00) || (reqAddr >= SYS_LIMIT) ||
                   (reqIsWrite && reqSys && !iSysWrEn);
        grant    = (state == IDLE) && (iLoadReq || iFetchReq);
    end

    // State register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    if (reqFault) begin
                        nextState = RESP_FAULT;
                    end else if (reqIsWrite) begin
                        nextState = WR;
                    end else begin
                        nextState = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (waitCnt == '0) begin
                    nextState = RD_RESP;
                end
            end
            RD_RESP:    nextState = IDLE;
            WR:         nextState = IDLE;
            RESP_FAULT: nextState = IDLE;
            default:    nextState = IDLE;
        endcase
    end

    // Read latency counter, loaded at grant and counted down in RD_WAIT
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            waitCnt <= '0;
        end else if (grant) begin
            waitCnt <= CNT_W'(MEM_LAT - 1);
        end else if ((state == RD_WAIT) && (waitCnt != '0)) begin
            waitCnt <= waitCnt - 1'b1;
        end
    end

    // Registered outputs, computed from the transition being taken
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oFetchValid <= 1'b0;
            oLoadAck    <= 1'b0;
            oFault      <= 1'b0;
            oFaultAddr  <= '0;
            oMemWrUser  <= 1'b0;
            oMemWrSys   <= 1'b0;
            oMemAddr    <= '0;
            oMemWData   <= '0;
            oBusy       <= 1'b0;
            sysSelQ     <= 1'b0;
            fetchDataQ  <= '0;
        end else begin
            oFetchValid <= 1'b0;
            oLoadAck    <= 1'b0;
            oFault      <= 1'b0;
            oMemWrUser  <= 1'b0;
            oMemWrSys   <= 1'b0;
            oBusy       <= (nextState != IDLE);

            if (grant) begin
                if (reqFault) begin
                    // Faulted access: respond next cycle, never touch memory
                    oFault     <= 1'b1;
                    oFaultAddr <= reqAddr;
                    if (reqIsWrite) begin
                        oLoadAck <= 1'b1;
                    end else begin
                        oFetchValid <= 1'b1;
                        fetchDataQ  <= '0;
                    end
                end else begin
                    oMemAddr <= reqAddr[13:2];
                    sysSelQ  <= reqSys;
                    if (reqIsWrite) begin
                        oMemWData  <= iLoadData;
                        oMemWrUser <= !reqSys;
                        oMemWrSys  <= reqSys;
                        oLoadAck   <= 1'b1;
                    end
                end
            end

            if ((state == RD_WAIT) && (nextState == RD_RESP)) begin
                oFetchValid <= 1'b1;
            end

            if (state == RD_RESP) begin
                fetchDataQ <= bankData;
            end
        end
    end

    // Bank data is only valid in the response cycle; hold it afterwards
    always_comb begin
        bankData   = sysSelQ ? iMemDataSys : iMemDataUser;
        oFetchData = (state == RD_RESP) ? bankData : fetchDataQ;
    end

endmodule

// File: tb/tb_code_mem_ctrl.sv
module tb_code_mem_ctrl;

    typedef struct {
        logic        isLoad;
        logic [63:0] addr;
        logic [63:0] data;
        logic        sysWrEn;
        logic        expFault;
        logic        expSys;
        logic [63:0] expData;
    } vec_t;

    typedef struct {
        logic        isLoad;
        logic        fault;
        logic        sys;
        logic [63:0] data;
        logic [63:0] addr;
    } exp_t;

    int errors = 0;
    int checks = 0;
    exp_t sbq[$];
    exp_t monE;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        fetchReq = 1'b0;
    logic [63:0] fetchAddr = '0;
    logic        loadReq = 1'b0;
    logic [63:0] loadAddr = '0;
    logic [63:0] loadData = '0;
    logic        sysWrEn = 1'b0;
    logic [63:0] fetchData;
    logic        fetchValid;
    logic        loadAck;
    logic [11:0] memAddr;
    logic [63:0] memWData;
    logic        memWrUser;
    logic        memWrSys;
    logic [63:0] memDataUser = '0;
    logic [63:0] memDataSys = '0;
    logic        fault;
    logic [63:0] faultAddr;
    logic        busy;

    // Second instance with MEM_LAT=3, fetch only
    logic        rst3 = 1'b1;
    logic        f3Req = 1'b0;
    logic [63:0] f3Addr = '0;
    logic        l3Req = 1'b0;
    logic [63:0] l3Addr = '0;
    logic [63:0] l3Data = '0;
    logic        l3SysWrEn = 1'b0;
    logic [63:0] f3Data;
    logic        f3Valid;
    logic        l3Ack;
    logic [11:0] mem3Addr;
    logic [63:0] mem3WData;
    logic        mem3WrUser;
    logic        mem3WrSys;
    logic [63:0] u3a = '0, u3b = '0, u3c = '0;
    logic [63:0] s3a = '0, s3b = '0, s3c = '0;
    logic        fault3;
    logic [63:0] fault3Addr;
    logic        busy3;

    always #5 iCLK = ~iCLK;

    code_mem_ctrl #(.MEM_LAT(1)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iFetchReq(fetchReq), .iFetchAddr(fetchAddr),
        .oFetchData(fetchData), .oFetchValid(fetchValid),
        .iLoadReq(loadReq), .iLoadAddr(loadAddr), .iLoadData(loadData),
        .iSysWrEn(sysWrEn), .oLoadAck(loadAck),
        .oMemAddr(memAddr), .oMemWData(memWData),
        .oMemWrUser(memWrUser), .oMemWrSys(memWrSys),
        .iMemDataUser(memDataUser), .iMemDataSys(memDataSys),
        .oFault(fault), .oFaultAddr(faultAddr), .oBusy(busy)
    );

    code_mem_ctrl #(.MEM_LAT(3)) dut3 (
        .iCLK(iCLK), .iRST(rst3),
        .iFetchReq(f3Req), .iFetchAddr(f3Addr),
        .oFetchData(f3Data), .oFetchValid(f3Valid),
        .iLoadReq(l3Req), .iLoadAddr(l3Addr), .iLoadData(l3Data),
        .iSysWrEn(l3SysWrEn), .oLoadAck(l3Ack),
        .oMemAddr(mem3Addr), .oMemWData(mem3WData),
        .oMemWrUser(mem3WrUser), .oMemWrSys(mem3WrSys),
        .iMemDataUser(u3c), .iMemDataSys(s3c),
        .oFault(fault3), .oFaultAddr(fault3Addr), .oBusy(busy3)
    );

    // Memory contents: user word 4 is 0xDEADBEEF, others encode their index
    function automatic logic [63:0] userWord(input logic [11:0] a);
        logic [9:0] idx;
        idx = a[9:0];
        if (idx == 10'd4) return 64'h0000_0000_DEAD_BEEF;
        return 64'hC0DE_0000_0000_0000 | 64'(idx);
    endfunction

    function automatic logic [63:0] sysWord(input logic [11:0] a);
        logic [8:0] idx;
        idx = a[8:0];
        return 64'h5E50_0000_0000_0000 | 64'(idx);
    endfunction

    // Synchronous memory models: 1-cycle and 3-cycle read latency
    always @(posedge iCLK) begin
        memDataUser <= userWord(memAddr);
        memDataSys  <= sysWord(memAddr);
        u3a <= userWord(mem3Addr);
        u3b <= u3a;
        u3c <= u3b;
        s3a <= sysWord(mem3Addr);
        s3b <= s3a;
        s3c <= s3b;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every response pops and checks one expectation
    always @(negedge iCLK) begin
        if (fetchValid || loadAck) begin
            if (sbq.size() == 0) begin
                check("unexpected_resp", 64'(1), 64'(0));
            end else begin
                monE = sbq.pop_front();
                check("resp_kind", 64'({loadAck, fetchValid}), monE.isLoad ? 64'h2 : 64'h1);
                check("fault_flag", 64'(fault), 64'(monE.fault));
                if (monE.fault) begin
                    check("fault_addr", faultAddr, monE.addr);
                    check("fault_no_write", 64'({memWrUser, memWrSys}), 64'(0));
                    if (!monE.isLoad) check("fault_data", fetchData, 64'(0));
                end else if (monE.isLoad) begin
                    check("wr_en", 64'({memWrUser, memWrSys}), monE.sys ? 64'h1 : 64'h2);
                    check("wr_addr", 64'(memAddr), 64'(monE.addr[13:2]));
                    check("wr_data", memWData, monE.data);
                end else begin
                    check("rd_data", fetchData, monE.data);
                    check("rd_addr", 64'(memAddr), 64'(monE.addr[13:2]));
                end
            end
        end else if (memWrUser || memWrSys || fault) begin
            check("stray_pulse", 64'({memWrUser, memWrSys, fault}), 64'(0));
        end
    end

    task automatic runOp(input vec_t v);
        int n;
        bit done;
        int expLat;
        exp_t e;
        n = 0;
        while (busy && n < 20) begin
            @(negedge iCLK);
            n++;
        end
        check("idle_before_op", 64'(busy), 64'(0));
        e.isLoad = v.isLoad;
        e.fault  = v.expFault;
        e.sys    = v.expSys;
        e.data   = v.isLoad ? v.data : v.expData;
        e.addr   = v.addr;
        sbq.push_back(e);
        if (v.isLoad) begin
            loadReq = 1'b1; loadAddr = v.addr; loadData = v.data; sysWrEn = v.sysWrEn;
        end else begin
            fetchReq = 1'b1; fetchAddr = v.addr;
        end
        expLat = (v.isLoad || v.expFault) ? 1 : 2;
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge iCLK);
            n++;
            done = fetchValid || loadAck;
        end
        loadReq  = 1'b0;
        fetchReq = 1'b0;
        check("latency", 64'(n), 64'(expLat));
        @(negedge iCLK);
        check("wr_en_after", 64'({memWrUser, memWrSys}), 64'(0));
        if (!v.isLoad) check("fetch_data_hold", fetchData, v.expData);
    endtask

    vec_t vecs [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cnt;
        int resp;
        exp_t e;

        //             isLoad addr                    data          sysWr fault sys  expData
        vecs[0]  = '{1'b0, 64'h0000_0010,          64'h0,        1'b0, 1'b0, 1'b0, 64'h0000_0000_DEAD_BEEF};
        vecs[1]  = '{1'b1, 64'h0000_1008,          64'h1234,     1'b1, 1'b0, 1'b1, 64'h0};
        vecs[2]  = '{1'b1, 64'h0000_1000,          64'h5555,     1'b0, 1'b1, 1'b0, 64'h0};
        vecs[3]  = '{1'b0, 64'h0000_1800,          64'h0,        1'b0, 1'b1, 1'b0, 64'h0};
        vecs[4]  = '{1'b0, 64'h0000_0006,          64'h0,        1'b0, 1'b1, 1'b0, 64'h0};
        vecs[5]  = '{1'b1, 64'h0000_0FFC,          64'hAAAA,     1'b0, 1'b0, 1'b0, 64'h0};
        vecs[6]  = '{1'b1, 64'h0000_17FC,          64'hBBBB_CCCC, 1'b1, 1'b0, 1'b1, 64'h0};
        vecs[7]  = '{1'b1, 64'h0000_1800,          64'h9999,     1'b1, 1'b1, 1'b0, 64'h0};
        vecs[8]  = '{1'b0, 64'h0000_1100,          64'h0,        1'b0, 1'b0, 1'b1, 64'h5E50_0000_0000_0040};
        vecs[9]  = '{1'b0, 64'h0000_0FFC,          64'h0,        1'b0, 1'b0, 1'b0, 64'hC0DE_0000_0000_03FF};
        vecs[10] = '{1'b1, 64'h0000_0002,          64'h7777,     1'b1, 1'b1, 1'b0, 64'h0};
        vecs[11] = '{1'b0, 64'h0000_17FC,          64'h0,        1'b0, 1'b0, 1'b1, 64'h5E50_0000_0000_01FF};
        vecs[12] = '{1'b0, 64'hFFFF_FFFF_0000_0000, 64'h0,       1'b0, 1'b1, 1'b0, 64'h0};

        repeat (3) @(negedge iCLK);
        check("reset_ctrl", 64'({fetchValid, loadAck, memWrUser, memWrSys, fault, busy}), 64'(0));
        check("reset_addr", 64'(memAddr), 64'(0));
        check("reset_data", fetchData | memWData | faultAddr, 64'(0));
        iRST = 1'b0;
        rst3 = 1'b0;

        foreach (vecs[i]) runOp(vecs[i]);

        // Fetch dropped right after grant still completes exactly once
        @(negedge iCLK);
        e.isLoad = 1'b0; e.fault = 1'b0; e.sys = 1'b0;
        e.data = 64'h0000_0000_DEAD_BEEF; e.addr = 64'h10;
        sbq.push_back(e);
        fetchReq = 1'b1; fetchAddr = 64'h10;
        @(negedge iCLK);
        fetchReq = 1'b0;
        cnt = 0; n = 0;
        for (int k = 2; k <= 7; k++) begin
            @(negedge iCLK);
            if (fetchValid) begin
                cnt++;
                if (n == 0) n = k;
            end
        end
        check("drop_pulse_count", 64'(cnt), 64'(1));
        check("drop_latency", 64'(n), 64'(2));

        // Both requesters held for four operations after a fresh reset
        iRST = 1'b1;
        @(negedge iCLK);
        check("reset_idle", 64'(busy), 64'(0));
        iRST = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef CODE_MEM_CTRL_RR_EN
            e.isLoad = (k % 2 == 0);
`else
            e.isLoad = 1'b1;
`endif
            e.fault = 1'b0; e.sys = 1'b0;
            e.data = e.isLoad ? 64'h77 : 64'h0000_0000_DEAD_BEEF;
            e.addr = e.isLoad ? 64'h40 : 64'h10;
            sbq.push_back(e);
        end
        loadReq = 1'b1; loadAddr = 64'h40; loadData = 64'h77; sysWrEn = 1'b0;
        fetchReq = 1'b1; fetchAddr = 64'h10;
        resp = 0; n = 0;
        while (resp < 4 && n < 40) begin
            @(negedge iCLK);
            n++;
            if (fetchValid || loadAck) resp++;
        end
        loadReq = 1'b0;
        fetchReq = 1'b0;
        check("arb_resp_count", 64'(resp), 64'(4));
        repeat (4) @(negedge iCLK);
        check("sb_empty", 64'(sbq.size()), 64'(0));

        // MEM_LAT=3: reset during RD_WAIT aborts the read
        f3Req = 1'b1; f3Addr = 64'h10;
        repeat (2) @(negedge iCLK);
        check("lat3_busy_wait", 64'(busy3), 64'(1));
        check("lat3_no_early_valid", 64'(f3Valid), 64'(0));
        #2 rst3 = 1'b1;
        #1;
        check("lat3_reset_outputs", 64'({busy3, f3Valid, l3Ack, mem3WrUser, mem3WrSys, fault3}), 64'(0));
        check("lat3_reset_addr", 64'(mem3Addr), 64'(0));
        check("lat3_reset_data", f3Data, 64'(0));
        f3Req = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge iCLK);
            if (f3Valid) cnt++;
        end
        rst3 = 1'b0;
        repeat (3) begin
            @(negedge iCLK);
            if (f3Valid) cnt++;
        end
        check("lat3_aborted_no_valid", 64'(cnt), 64'(0));
        f3Req = 1'b1; f3Addr = 64'h14;
        n = 0;
        while (!f3Valid && n < 20) begin
            @(negedge iCLK);
            n++;
        end
        f3Req = 1'b0;
        check("lat3_latency", 64'(n), 64'(4));
        check("lat3_data", f3Data, 64'hC0DE_0000_0000_0005);
        check("lat3_fault", 64'(fault3), 64'(0));
        @(negedge iCLK);
        check("lat3_single_pulse", 64'(f3Valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/code_mem_ctrl.md
Name: code_mem_ctrl

Overview:
Sequencing/arbitration controller in front of the code memory banks (user 0x0000–0x0FFF, system 0x1000–0x17FF). Shares the single memory port between the instruction-fetch requester and the boot/debug loader, and issues each access with correct timing. Decodes the bank, generates one-cycle write-enable pulses, enforces system-bank write protection, and reports faults.

Parameters:
USER_LIMIT, 64'h0000_1000, first address past the user bank
SYS_LIMIT, 64'h0000_1800, first address past the system bank
MEM_LAT, 1, memory read latency in cycles after the address is presented (1–3)

Ports:
iCLK  in  1  system clock
iRST  in  1  asynchronous, active-high reset
iFetchReq  in  1  fetch request, held until oFetchValid
iFetchAddr  in  64  fetch byte address
oFetchData  out  64  fetch read data
oFetchValid  out  1  one-cycle fetch completion pulse
iLoadReq  in  1  loader write request, held until oLoadAck
iLoadAddr  in  64  loader byte address
iLoadData  in  64  loader write data
iSysWrEn  in  1  permits writes to the system bank
oLoadAck  out  1  one-cycle loader completion pulse
oMemAddr  out  12  word index (address[13:2]) to both banks
oMemWData  out  64  write data to both banks
oMemWrUser  out  1  user-bank write enable
oMemWrSys  out  1  system-bank write enable
iMemDataUser  in  64  user-bank read data
iMemDataSys  in  64  system-bank read data
oFault  out  1  one-cycle pulse with a faulted completion
oFaultAddr  out  64  address of the most recent fault, held
oBusy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, FSM = IDLE, priority pointer = loader. Reset is asynchronous. If reset is asserted mid-operation, the operation is aborted, write enables drop immediately, and no ack or valid pulse is produced.
- FSM states are IDLE, RD_WAIT, RD_RESP, WR, RESP_FAULT.
- Arbitration in IDLE: the loader has fixed priority over fetch. Grant happens in cycle T; the address, data and request type are registered at T.
- Fault check at grant: a request faults if addr[1:0] != 0, if addr >= SYS_LIMIT, or if it is a loader write with USER_LIMIT <= addr < SYS_LIMIT and iSysWrEn = 0. A faulted request goes to RESP_FAULT.
- Read: oMemAddr is presented from T+1. The FSM waits in RD_WAIT for MEM_LAT cycles. In RD_RESP (cycle T+1+MEM_LAT) it selects bank data using the registered address, drives oFetchData and pulses oFetchValid, then returns to IDLE. oFetchData holds its value until the next read completes.
- Write: in WR (cycle T+1), oMemAddr and oMemWData are driven and exactly one of oMemWrUser/oMemWrSys is high for exactly one cycle, with oLoadAck pulsed in the same cycle. The FSM then returns to IDLE.
- RESP_FAULT (cycle T+1): no memory write occurs. The FSM pulses oFault together with oLoadAck (write) or with oFetchValid and oFetchData = 0 (read). It also captures oFaultAddr.
- Back-to-back: a new grant is possible in the cycle after the response pulse. Throughput is 1 op per 2 + MEM_LAT cycles for reads and 1 op per 2 cycles for writes.
- If a requester drops its request after grant, the operation still completes and the response pulse is still issued. Requests are sampled only in IDLE.
- Simultaneous iFetchReq and iLoadReq in IDLE: the loader is granted and fetch waits. Fetch can starve while the loader streams.
- oMemAddr and oMemWData hold their last values while idle. Write enables are never high outside WR.

Optional Feature:
CODE_MEM_CTRL_RR_EN
- Defined: round-robin arbitration. After any grant, priority passes to the other requester. With continuous requests on both sides, grants strictly alternate, starting with the loader after reset.
- Undefined: fixed loader priority as described above.

Test Plan:
- Reset, then fetch at 0x0000_0010 with MEM_LAT=1, user bank word 4 = 0xDEAD_BEEF -> oMemAddr = 4 at T+1, oFetchValid with data 0xDEAD_BEEF at T+2, no write enables.
- Loader write 0x1234 at 0x0000_1008 with iSysWrEn=1 -> oMemWrSys high 1 cycle, oMemAddr = 0x402, oLoadAck in the same cycle, oMemWrUser = 0.
- Loader write at 0x0000_1000 with iSysWrEn=0 -> no write enable, oLoadAck + oFault at T+1, oFaultAddr = 0x1000. Also fetch at 0x0000_1800 and at 0x0000_0006 -> oFetchValid + oFault, data 0.
- Both requests held for 4 operations -> default build: 4 loader writes, fetch waits. With CODE_MEM_CTRL_RR_EN: loader, fetch, loader, fetch.
- Assert iRST during RD_WAIT with MEM_LAT=3 -> outputs 0 immediately, no oFetchValid, next fetch after release completes normally.
- Fetch request dropped the cycle after grant -> oFetchValid still pulses exactly once at T+1+MEM_LAT.
